// File: rtl/console_pkg.sv
// Shared constants, state type and byte classification for the console writer.
`timescale 1ns/1ps
package console_pkg;

  localparam int DEFAULT_COLS = 80;
  localparam int DEFAULT_ROWS = 30;

  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] BLANK_CHAR = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    CLEAR,
    CLRLINE,
    SCROLL_RD,
    SCROLL_WR
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/console_cursor.sv
// Text cursor: column, row and the running row base address (stepped by COLS, no multiply).
// Last-row newline wraps to row 0 unless CONSOLE_SCROLL_EN is defined, in which case the row holds.
`timescale 1ns/1ps
module console_cursor
  import console_pkg::*;
#(
  parameter int COLS   = DEFAULT_COLS,
  parameter int ROWS   = DEFAULT_ROWS,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              home,
  input  logic              col0,
  input  logic              advance,
  input  logic              back,
  input  logic              newline,
  output logic [6:0]        col,
  output logic [4:0]        row,
  output logic [ADDR_W-1:0] row_base,
  output logic              last_col,
  output logic              last_row
);

  assign last_col = (col == 7'(COLS - 1));
  assign last_row = (row == 5'(ROWS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (home) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else begin
      if (back)
        col <= col - 7'd1;
      else if (col0)
        col <= '0;
      else if (advance)
        col <= col + 7'd1;

      if (newline) begin
        if (!last_row) begin
          row      <= row + 5'd1;
          row_base <= row_base + ADDR_W'(COLS);
        end
`ifndef CONSOLE_SCROLL_EN
        else begin
          row      <= '0;
          row_base <= '0;
        end
`endif
      end
    end
  end

endmodule

// File: rtl/console_writer.sv
// Console writer: turns accepted ASCII bytes into granted character-buffer accesses.
// Optional scrolling on last-row newline is compiled in with CONSOLE_SCROLL_EN.
`timescale 1ns/1ps
module console_writer
  import console_pkg::*;
#(
  parameter int         COLS       = DEFAULT_COLS,
  parameter int         ROWS       = DEFAULT_ROWS,
  parameter int         ADDR_W     = 12,
  parameter logic [7:0] BLANK_CHAR = console_pkg::BLANK_CHAR
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

`ifdef CONSOLE_SCROLL_EN
  localparam state_t            NL_STATE   = SCROLL_RD;
  localparam logic              NL_WRE     = 1'b0;
  localparam logic [ADDR_W-1:0] NL_AD      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LINE_FIRST = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] LAST_DST   = ADDR_W'((ROWS - 1) * COLS - 1);
  logic cap;
`else
  localparam state_t            NL_STATE   = CLRLINE;
  localparam logic              NL_WRE     = 1'b1;
  localparam logic [ADDR_W-1:0] NL_AD      = '0;
  localparam logic [ADDR_W-1:0] LINE_FIRST = '0;
  logic dout_unused;
  assign dout_unused = ^mem_dout;
`endif
  localparam logic [ADDR_W-1:0] LINE_LAST = LINE_FIRST + ADDR_W'(COLS - 1);

  state_t            state;
  logic              adv;
  logic [6:0]        col;
  logic [4:0]        row;
  logic [ADDR_W-1:0] row_base;
  logic              last_col, last_row;
  logic              accept, granted, wr_done, wrap, nl;
  logic              c_home, c_back, c_col0, c_adv;
  logic [ADDR_W-1:0] cur_ad;

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign mem_ce     = mem_req & mem_gnt;
  assign cursor_col = col;
  assign cursor_row = row;

  // Cursor commands are decoded from the same conditions the FSM acts on,
  // so cursor and state move on the same edge.
  always_comb begin
    accept  = in_valid && (state == IDLE);
    granted = mem_req && mem_gnt;
    wr_done = (state == WRITE) && granted;
    wrap    = wr_done && adv && last_col;
    nl      = (accept && (in_data == CHAR_LF)) || wrap;
    c_home  = (state == CLEAR) && granted && (mem_ad == LAST_CELL);
    c_back  = accept && (in_data == CHAR_BS) && (col != '0);
    c_col0  = (accept && (in_data == CHAR_CR)) || wrap;
    c_adv   = wr_done && adv && !last_col;
    cur_ad  = row_base + ADDR_W'(col);
  end

  console_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk      (clk),
    .resetn   (resetn),
    .home     (c_home),
    .col0     (c_col0),
    .advance  (c_adv),
    .back     (c_back),
    .newline  (nl),
    .col      (col),
    .row      (row),
    .row_base (row_base),
    .last_col (last_col),
    .last_row (last_row)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      adv     <= 1'b0;
      mem_req <= 1'b0;
      mem_wre <= 1'b0;
      mem_ad  <= '0;
      mem_din <= '0;
`ifdef CONSOLE_SCROLL_EN
      cap     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_printable(in_data)) begin
              state   <= WRITE;
              mem_req <= 1'b1;
              mem_wre <= 1'b1;
              mem_ad  <= cur_ad;
              mem_din <= in_data;
              adv     <= 1'b1;
            end else if ((in_data == CHAR_BS) && (col != '0)) begin
              state   <= WRITE;
              mem_req <= 1'b1;
              mem_wre <= 1'b1;
              mem_ad  <= cur_ad - ADDR_W'(1);
              mem_din <= BLANK_CHAR;
              adv     <= 1'b0;
            end else if (in_data == CHAR_FF) begin
              state   <= CLEAR;
              mem_req <= 1'b1;
              mem_wre <= 1'b1;
              mem_ad  <= '0;
              mem_din <= BLANK_CHAR;
            end else if ((in_data == CHAR_LF) && last_row) begin
              state   <= NL_STATE;
              mem_req <= 1'b1;
              mem_wre <= NL_WRE;
              mem_ad  <= NL_AD;
              mem_din <= BLANK_CHAR;
            end
          end
        end
        WRITE: begin
          if (granted) begin
            if (wrap && last_row) begin
              state   <= NL_STATE;
              mem_wre <= NL_WRE;
              mem_ad  <= NL_AD;
              mem_din <= BLANK_CHAR;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
              mem_wre <= 1'b0;
            end
          end
        end
        CLEAR: begin
          if (granted) begin
            if (mem_ad == LAST_CELL) begin
              state   <= IDLE;
              mem_req <= 1'b0;
              mem_wre <= 1'b0;
            end else begin
              mem_ad <= mem_ad + ADDR_W'(1);
            end
          end
        end
        CLRLINE: begin
          if (granted) begin
            if (mem_ad == LINE_LAST) begin
              state   <= IDLE;
              mem_req <= 1'b0;
              mem_wre <= 1'b0;
            end else begin
              mem_ad <= mem_ad + ADDR_W'(1);
            end
          end
        end
`ifdef CONSOLE_SCROLL_EN
        SCROLL_RD: begin
          if (granted) begin
            state   <= SCROLL_WR;
            mem_req <= 1'b0;
            mem_wre <= 1'b1;
            mem_ad  <= mem_ad - ADDR_W'(COLS);
            cap     <= 1'b1;
          end
        end
        // First cycle only captures the read data; the write request follows.
        SCROLL_WR: begin
          if (cap) begin
            cap     <= 1'b0;
            mem_din <= mem_dout;
            mem_req <= 1'b1;
          end else if (granted) begin
            if (mem_ad == LAST_DST) begin
              state   <= CLRLINE;
              mem_ad  <= LINE_FIRST;
              mem_din <= BLANK_CHAR;
            end else begin
              state   <= SCROLL_RD;
              mem_wre <= 1'b0;
              mem_ad  <= mem_ad + ADDR_W'(COLS + 1);
            end
          end
        end
`endif
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_wre <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_console_writer.sv
// Bench for console_writer: buffer model plus a screen-level reference model of the text console.
`timescale 1ns/1ps
module tb_console_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  typedef struct packed {
    logic        wre;
    logic [11:0] ad;
    logic [7:0]  din;
  } acc_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        mem_gnt = 1'b0;
  logic        in_ready, mem_req, mem_ce, mem_wre, busy;
  logic [11:0] mem_ad;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout = 8'h00;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  logic [7:0]  mem [0:4095] = '{default: 8'h00};
  logic [7:0]  scr [0:4095] = '{default: 8'h00};
  acc_t        log_q[$];
  int          mcol = 0, mrow = 0;
  int          gmode = 0;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  console_writer #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .ADDR_W     (12),
    .BLANK_CHAR (8'h20)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_ce     (mem_ce),
    .mem_wre    (mem_wre),
    .mem_ad     (mem_ad),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  // Single-port buffer: registered read output, data valid the cycle after a granted read.
  always @(posedge clk) begin
    if (mem_ce) begin
      log_q.push_back({mem_wre, mem_ad, mem_din});
      if (mem_wre) mem[mem_ad] <= mem_din;
      else         mem_dout   <= mem[mem_ad];
    end
  end

  always @(negedge clk)
    mem_gnt = (gmode == 1) || ((gmode == 2) && ($urandom_range(1) == 1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_newline();
    if (mrow < ROWS - 1) mrow++;
    else begin
`ifdef CONSOLE_SCROLL_EN
      for (int i = 0; i < (ROWS - 1) * COLS; i++) scr[i] = scr[i + COLS];
      for (int i = (ROWS - 1) * COLS; i < CELLS; i++) scr[i] = 8'h20;
`else
      mrow = 0;
      for (int i = 0; i < COLS; i++) scr[i] = 8'h20;
`endif
    end
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[mrow * COLS + mcol] = b;
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        m_newline();
      end
    end else if (b == 8'h0D) mcol = 0;
    else if (b == 8'h0A) m_newline();
    else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        scr[mrow * COLS + mcol] = 8'h20;
      end
    end else if (b == 8'h0C) begin
      for (int i = 0; i < CELLS; i++) scr[i] = 8'h20;
      mcol = 0;
      mrow = 0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", busy, 0);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    m_byte(b);
    wait_idle();
  endtask

  task automatic chk_state(input string tag);
    int d = -1;
    for (int i = 0; i < CELLS; i++)
      if (mem[i] !== scr[i] && d < 0) d = i;
    chk({tag, "_screen_first_diff"}, d, -1);
    chk({tag, "_col"}, cursor_col, mcol);
    chk({tag, "_row"}, cursor_row, mrow);
  endtask

  function automatic int count_acc(input int from, input logic wre);
    int c = 0;
    for (int i = from; i < log_q.size(); i++)
      if (log_q[i].wre == wre) c++;
    return c;
  endfunction

  initial begin
    int q0, lowc, viol, errs;
    int hit [0:CELLS-1];
    logic [7:0] b;
    int r;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_wre", mem_wre, 0);
    chk("rst_mem_ad", mem_ad, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_col", cursor_col, 0);
    chk("rst_row", cursor_row, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;

    // 'H' with grant high: one write, in_ready low exactly one cycle
    gmode = 1;
    repeat (2) @(negedge clk);
    q0 = log_q.size();
    in_valid = 1'b1;
    in_data  = 8'h48;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lowc = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready !== 1'b1) lowc++;
    end
    m_byte(8'h48);
    chk("h_ready_low_cycles", lowc, 1);
    chk("h_access_count", log_q.size() - q0, 1);
    chk("h_ad", log_q[q0].ad, 0);
    chk("h_din", log_q[q0].din, 8'h48);
    chk("h_wre", log_q[q0].wre, 1);
    chk_state("h");

    // Grant withheld for 10 cycles after accepting 'A'
    gmode = 0;
    repeat (2) @(negedge clk);
    q0 = log_q.size();
    in_valid = 1'b1;
    in_data  = 8'h41;
    @(posedge clk);
    #1 in_data = 8'h42;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || mem_req !== 1'b1 || mem_ad !== 12'd1 ||
          mem_din !== 8'h41 || mem_wre !== 1'b1) viol++;
    end
    chk("hold_stable_violations", viol, 0);
    chk("hold_no_access", log_q.size() - q0, 0);
    in_valid = 1'b0;
    gmode = 1;
    wait_idle();
    m_byte(8'h41);
    chk("hold_access_count", log_q.size() - q0, 1);
    chk("hold_ad", log_q[q0].ad, 1);
    chk("hold_din", log_q[q0].din, 8'h41);
    chk_state("hold");

    // Full row of printables from (0,0)
    send(8'h0D);
    for (int i = 0; i < COLS; i++) send(8'(32 + $urandom_range(94)));
    chk("row_last_ad", log_q[log_q.size() - 1].ad, 79);
    chk_state("row");
    q0 = log_q.size();
    send(8'h0D);
    send(8'h08);
    chk("cr_bs_no_access", log_q.size() - q0, 0);
    chk_state("cr_bs");

    // Form feed with 50% grant
    gmode = 2;
    q0 = log_q.size();
    send(8'h0C);
    repeat (5) @(negedge clk);
    chk("ff_write_count", count_acc(q0, 1'b1), CELLS);
    chk("ff_access_count", log_q.size() - q0, CELLS);
    for (int i = 0; i < CELLS; i++) hit[i] = 0;
    errs = 0;
    for (int i = q0; i < log_q.size(); i++) begin
      if (log_q[i].ad >= 12'(CELLS) || log_q[i].din !== 8'h20) errs++;
      else hit[log_q[i].ad]++;
    end
    for (int i = 0; i < CELLS; i++) if (hit[i] != 1) errs++;
    chk("ff_each_addr_once", errs, 0);
    chk_state("ff");

    // Randomized byte stream against the reference model
    for (int k = 0; k < 120; k++) begin
      r = $urandom_range(99);
      if (r < 80)      b = 8'(32 + $urandom_range(94));
      else if (r < 88) b = 8'h0D;
      else if (r < 93) b = 8'h0A;
      else if (r < 98) b = 8'h08;
      else             b = (r == 98) ? 8'h7F : 8'(8'h80 + $urandom_range(127));
      send(b);
      chk_state("rand");
    end

    // Fill 29 rows, then a newline on the last row
    gmode = 1;
    send(8'h0C);
    for (int k = 0; k < ROWS - 1; k++) begin
      repeat (3) send(8'(32 + $urandom_range(94)));
      send(8'h0D);
      send(8'h0A);
    end
    chk("lf29_row", cursor_row, ROWS - 1);
    send(8'(32 + $urandom_range(94)));
    send(8'(32 + $urandom_range(94)));
    gmode = 2;
    q0 = log_q.size();
    send(8'h0A);
`ifdef CONSOLE_SCROLL_EN
    chk("scroll_reads", count_acc(q0, 1'b0), (ROWS - 1) * COLS);
    chk("scroll_writes", count_acc(q0, 1'b1), CELLS);
    chk("scroll_row", cursor_row, ROWS - 1);
`else
    chk("wrap_writes", count_acc(q0, 1'b1), COLS);
    chk("wrap_reads", count_acc(q0, 1'b0), 0);
    errs = 0;
    for (int i = q0; i < log_q.size(); i++)
      if (log_q[i].ad >= 12'(COLS) || log_q[i].din !== 8'h20) errs++;
    chk("wrap_addr_range", errs, 0);
    chk("wrap_row", cursor_row, 0);
`endif
    chk_state("last_lf");

    // Reset in the middle of a clear
    gmode = 1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h0C;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (100) @(negedge clk);
    chk("midclr_busy_before", busy, 1);
    #2 resetn = 1'b0;
    #1;
    chk("midclr_req_async", mem_req, 0);
    chk("midclr_ready", in_ready, 1);
    chk("midclr_busy", busy, 0);
    chk("midclr_col", cursor_col, 0);
    chk("midclr_row", cursor_row, 0);
    q0 = log_q.size();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (50) @(negedge clk);
    chk("midclr_no_writes", log_q.size() - q0, 0);
    chk("midclr_idle_after", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
